// File: rtl/cfa_window_fetch.sv
// Raster-order 5x5 raw window fetcher with reflect-101 borders for the CFA green-interpolation core.
// Optional feature: define CFA_WIN_ZERO_PAD_EN to load zeros for taps outside the frame.
module cfa_window_fetch #(
    parameter int DATA_W = 12,
    parameter int DIM_W  = 11,
    parameter int ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      rowMax,
    input  logic [DIM_W-1:0]      colMax,
    input  logic [DATA_W-1:0]     raw,
    output logic [ADDR_W-1:0]     readAddress,
    output logic [25*DATA_W-1:0]  window,
    output logic                  winValid,
    input  logic                  winReady,
    output logic [DIM_W-1:0]      centreRow,
    output logic [DIM_W-1:0]      centreCol,
    output logic                  colUpdate,
    output logic                  rowUpdate,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        PRESENT = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] taps [5][5];
    logic [2:0]        fi;
    logic [2:0]        fj;

    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              fill_last;
    logic              shift_last;

    logic              load;
    logic [DIM_W-1:0]  f_crow;
    logic [DIM_W-1:0]  f_ccol;
    logic [2:0]        f_i;
    logic [2:0]        f_j;
    int                row_idx;
    int                col_idx;
    logic [DIM_W-1:0]  m_row;
    logic [DIM_W-1:0]  m_col;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] cap;

    function automatic logic [DIM_W-1:0] reflect(input int idx, input int n);
        int m;
        if (idx < 0)
            m = -idx;
        else if (idx > n - 1)
            m = 2 * (n - 1) - idx;
        else
            m = idx;
        return DIM_W'(m);
    endfunction

    assign accept     = (state == PRESENT) && winValid && winReady;
    assign col_last   = (centreCol == colMax - DIM_W'(1));
    assign row_last   = (centreRow == rowMax - DIM_W'(1));
    assign fill_last  = (fi == 3'd4) && (fj == 3'd4);
    assign shift_last = (fi == 3'd4);

    // The address register is loaded one step ahead, so the tap it names is
    // captured on the following edge while raw is valid for it.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        load   = 1'b0;
        f_crow = centreRow;
        f_ccol = centreCol;
        f_i    = fi;
        f_j    = fj;
        case (state)
            IDLE: begin
                if (start) begin
                    load   = 1'b1;
                    f_crow = '0;
                    f_ccol = '0;
                    f_i    = 3'd0;
                    f_j    = 3'd0;
                end
            end
            FILL: begin
                if (!fill_last) begin
                    load = 1'b1;
                    if (fi == 3'd4) begin
                        f_i = 3'd0;
                        f_j = fj + 3'd1;
                    end else begin
                        f_i = fi + 3'd1;
                    end
                end
            end
            SHIFT: begin
                if (!shift_last) begin
                    load = 1'b1;
                    f_i  = fi + 3'd1;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (!col_last) begin
                        load   = 1'b1;
                        f_ccol = centreCol + DIM_W'(1);
                        f_i    = 3'd0;
                        f_j    = 3'd4;
                    end else if (!row_last) begin
                        load   = 1'b1;
                        f_crow = centreRow + DIM_W'(1);
                        f_ccol = '0;
                        f_i    = 3'd0;
                        f_j    = 3'd0;
                    end
                end
            end
            default: ;
        endcase
        row_idx = int'(f_crow) + int'(f_i) - 2;
        col_idx = int'(f_ccol) + int'(f_j) - 2;
        m_row   = reflect(row_idx, int'(rowMax));
        m_col   = reflect(col_idx, int'(colMax));
        f_addr  = ADDR_W'(int'(m_row) * int'(colMax) + int'(m_col));
    end

`ifdef CFA_WIN_ZERO_PAD_EN
    logic f_pad;
    logic pad_q;

    assign f_pad = (row_idx < 0) || (row_idx > int'(rowMax) - 1) ||
                   (col_idx < 0) || (col_idx > int'(colMax) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pad_q <= 1'b0;
        else if (load)
            pad_q <= f_pad;
    end

    assign cap = pad_q ? '0 : raw;
`else
    assign cap = raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fi          <= 3'd0;
            fj          <= 3'd0;
            readAddress <= '0;
            centreRow   <= '0;
            centreCol   <= '0;
            winValid    <= 1'b0;
            colUpdate   <= 1'b0;
            rowUpdate   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            // NOTE: the tap array is reset because the window port must read 0 out of reset.
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    taps[i][j] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
            colUpdate <= 1'b0;
            rowUpdate <= 1'b0;
            done      <= 1'b0;
            if (load) begin
                readAddress <= f_addr;
                fi          <= f_i;
                fj          <= f_j;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        busy      <= 1'b1;
                        centreRow <= '0;
                        centreCol <= '0;
                    end
                end
                FILL: begin
                    taps[fi][fj] <= cap;
                    if (fill_last) begin
                        state    <= PRESENT;
                        winValid <= 1'b1;
                    end
                end
                SHIFT: begin
                    taps[fi][4] <= cap;
                    if (shift_last) begin
                        state    <= PRESENT;
                        winValid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        winValid  <= 1'b0;
                        colUpdate <= 1'b1;
                        rowUpdate <= col_last;
                        if (!col_last) begin
                            state     <= SHIFT;
                            centreCol <= centreCol + DIM_W'(1);
                            for (int i = 0; i < 5; i++)
                                for (int j = 0; j < 4; j++)
                                    taps[i][j] <= taps[i][j+1];
                        end else if (!row_last) begin
                            state     <= FILL;
                            centreRow <= centreRow + DIM_W'(1);
                            centreCol <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                window[(i*5+j)*DATA_W +: DATA_W] = taps[i][j];
    end

endmodule
